// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: RV32 opcode
// constants, controller state encodings and the enable/kill bundle type.
package pipe_hazard_ctrl_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   typedef enum logic [1:0] {
      PHC_BOOT     = 2'd0,
      PHC_RUN      = 2'd1,
      PHC_MEM_WAIT = 2'd2
   } phc_state_e;

   // One pipeline-control decision: every enable and kill driven in a cycle.
   typedef struct packed {
      logic pc_en;
      logic fd_en;
      logic fd_kill;
      logic x_kill;
      logic xmw_en;
   } phc_ctrl_t;

   function automatic phc_ctrl_t phc_ctrl(input logic pc_en, input logic fd_en,
                                          input logic fd_kill, input logic x_kill,
                                          input logic xmw_en);
      phc_ctrl_t c;
      c.pc_en   = pc_en;
      c.fd_en   = fd_en;
      c.fd_kill = fd_kill;
      c.x_kill  = x_kill;
      c.xmw_en  = xmw_en;
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the core datapath (master) and the sequencing controller
// (slave): stage instructions and memory status in, enables/kills/counters out.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      inst_FD;
   logic [31:0]      inst_X;
   logic             redirect_X;
   logic             dmem_req_M;
   logic             dmem_ready;
   logic             imem_ready;
   logic             pc_en;
   logic             fd_en;
   logic             fd_kill;
   logic             x_kill;
   logic             xmw_en;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output inst_FD, inst_X, redirect_X, dmem_req_M, dmem_ready, imem_ready,
      input  pc_en, fd_en, fd_kill, x_kill, xmw_en, stall_cnt, flush_cnt
   );

   modport slave (
      input  inst_FD, inst_X, redirect_X, dmem_req_M, dmem_ready, imem_ready,
      output pc_en, fd_en, fd_kill, x_kill, xmw_en, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_src_decode.sv
// Register-usage decode of one RV32 instruction: which source registers it
// reads, its register fields and whether it is a load. Shared with forwarding.
module hazard_src_decode
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [31:0] i_inst,
   output logic        o_uses_rs1,
   output logic        o_uses_rs2,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic        o_is_load
);
   logic [6:0] w_opcode;
   logic       w_unused_bits;

   assign w_opcode      = i_inst[6:0];
   assign o_rd          = i_inst[11:7];
   assign o_rs1         = i_inst[19:15];
   assign o_rs2         = i_inst[24:20];
   assign o_is_load     = (w_opcode == LOAD);
   // funct3/funct7 never affect register usage.
   assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12]};

   // Source-register usage by opcode; anything unlisted reads no registers.
   always_comb begin
      o_uses_rs1 = 1'b0;
      o_uses_rs2 = 1'b0;
      case (w_opcode)
         OP, STORE, BRANCH: begin
            o_uses_rs1 = 1'b1;
            o_uses_rs2 = 1'b1;
         end
         OP_IMM, LOAD, JALR: o_uses_rs1 = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 4-stage core: owns the PC and
// pipeline-register enables/kills, handles boot, memory freeze, redirects
// and load-use stalls, and keeps saturating stall/flush counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  bus
);
   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   phc_state_e       r_state;
   phc_state_e       w_next_state;
   logic [3:0]       r_boot_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   phc_ctrl_t        w_ctrl;
   logic             w_flush;
   logic             w_stall;
   logic             w_mem_hold;
   logic             w_load_use;

   logic       w_fd_uses_rs1, w_fd_uses_rs2, w_fd_is_load;
   logic [4:0] w_fd_rs1, w_fd_rs2, w_fd_rd;
   logic       w_x_uses_rs1, w_x_uses_rs2, w_x_is_load;
   logic [4:0] w_x_rs1, w_x_rs2, w_x_rd;
   logic       w_unused_dec;

   hazard_src_decode u_dec_fd (
      .i_inst     (bus.inst_FD),
      .o_uses_rs1 (w_fd_uses_rs1),
      .o_uses_rs2 (w_fd_uses_rs2),
      .o_rs1      (w_fd_rs1),
      .o_rs2      (w_fd_rs2),
      .o_rd       (w_fd_rd),
      .o_is_load  (w_fd_is_load)
   );

   hazard_src_decode u_dec_x (
      .i_inst     (bus.inst_X),
      .o_uses_rs1 (w_x_uses_rs1),
      .o_uses_rs2 (w_x_uses_rs2),
      .o_rs1      (w_x_rs1),
      .o_rs2      (w_x_rs2),
      .o_rd       (w_x_rd),
      .o_is_load  (w_x_is_load)
   );

   // Only the consumer side of FD and the producer side of X matter here.
   assign w_unused_dec = ^{w_fd_rd, w_fd_is_load, w_x_uses_rs1, w_x_uses_rs2,
                           w_x_rs1, w_x_rs2};

   // A load in X whose result FD needs now cannot be forwarded yet.
   assign w_load_use = w_x_is_load && (w_x_rd != 5'd0) &&
                       ((w_fd_uses_rs1 && (w_fd_rs1 == w_x_rd)) ||
                        (w_fd_uses_rs2 && (w_fd_rs2 == w_x_rd)));

   // Once frozen, only dmem_ready releases the core; the release cycle
   // itself falls through to the normal run priorities.
   assign w_mem_hold = (r_state == PHC_MEM_WAIT) ? !bus.dmem_ready
                                                 : (bus.dmem_req_M && !bus.dmem_ready);

   // Next state and the enable/kill decision for this cycle.
   always_comb begin
      w_next_state = r_state;
      w_ctrl       = phc_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      w_flush      = 1'b0;
      case (r_state)
         PHC_BOOT: begin
            if (r_boot_cnt == BOOT_LAST) w_next_state = PHC_RUN;
         end
         default: begin
            w_next_state = PHC_RUN;
            if (w_mem_hold) begin
               w_next_state = PHC_MEM_WAIT;
               w_ctrl       = phc_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else if (bus.redirect_X) begin
               // Redirect beats load-use: the FD instruction is wrong-path.
               w_ctrl  = phc_ctrl(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
               w_flush = 1'b1;
            end else if (w_load_use) begin
               w_ctrl = phc_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            end else if (!bus.imem_ready) begin
               w_ctrl = phc_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            end else begin
               w_ctrl = phc_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            end
         end
      endcase
   end

   assign w_stall = (r_state != PHC_BOOT) && !w_ctrl.pc_en;

   // State register and boot counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PHC_BOOT;
         r_boot_cnt <= 4'd0;
      end else begin
         r_state <= w_next_state;
         if (r_state == PHC_BOOT) r_boot_cnt <= r_boot_cnt + 4'd1;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign bus.pc_en     = w_ctrl.pc_en;
   assign bus.fd_en     = w_ctrl.fd_en;
   assign bus.fd_kill   = w_ctrl.fd_kill;
   assign bus.x_kill    = w_ctrl.x_kill;
   assign bus.xmw_en    = w_ctrl.xmw_en;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;
   localparam int CW   = 5;
   localparam int BOOT = 2;
   localparam int MAXC = (1 << CW) - 1;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [31:0] LW_X5      = 32'h0000_A283; // lw  x5,0(x1)
   localparam logic [31:0] ADD_X6_X5  = 32'h0072_8333; // add x6,x5,x7
   localparam logic [31:0] LW_X0      = 32'h0000_A003; // lw  x0,0(x1)
   localparam logic [31:0] ADD_X6_X0  = 32'h0070_0333; // add x6,x0,x7

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state: boot cycles still to run, frozen-on-memory flag, counters.
   int   m_boot_left = BOOT;
   bit   m_wait = 1'b0;
   int   m_stall = 0;
   int   m_flush = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit reads_rs1(input logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011 || op == 7'b1100111;
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
   endfunction

   // Expected {pc_en, fd_en, fd_kill, x_kill, xmw_en} from the rule list.
   function automatic logic [4:0] model_out(output bit acted_redirect);
      logic [31:0] fd, x;
      bit lu;
      fd = bus.inst_FD;
      x  = bus.inst_X;
      acted_redirect = 1'b0;
      lu = (x[6:0] == 7'b0000011) && (x[11:7] != 0) &&
           ((reads_rs1(fd[6:0]) && fd[19:15] == x[11:7]) ||
            (reads_rs2(fd[6:0]) && fd[24:20] == x[11:7]));
      if (m_boot_left > 0)                        return 5'b00111;
      if (m_wait ? !bus.dmem_ready : (bus.dmem_req_M && !bus.dmem_ready))
                                                  return 5'b00000;
      if (bus.redirect_X) begin
         acted_redirect = 1'b1;                   return 5'b10111;
      end
      if (lu)                                     return 5'b00011;
      if (!bus.imem_ready)                        return 5'b00101;
      return 5'b11001;
   endfunction

   // Every-cycle comparison, then advance the model across the coming edge.
   always @(negedge clk) begin
      logic [4:0] e;
      bit fl;
      if (!rst_n) begin
         m_boot_left = BOOT;
         m_wait  = 1'b0;
         m_stall = 0;
         m_flush = 0;
      end
      e = model_out(fl);
      check("pc_en",   32'(bus.pc_en),   32'(e[4]));
      if (!e[2]) check("fd_en", 32'(bus.fd_en), 32'(e[3]));
      check("fd_kill", 32'(bus.fd_kill), 32'(e[2]));
      check("x_kill",  32'(bus.x_kill),  32'(e[1]));
      check("xmw_en",  32'(bus.xmw_en),  32'(e[0]));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
      if (rst_n) begin
         if (m_boot_left > 0) begin
            m_boot_left--;
         end else begin
            m_wait = (e == 5'b00000);
            if (!e[4] && m_stall < MAXC) m_stall++;
            if (fl && m_flush < MAXC) m_flush++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.inst_FD    = NOP_INST;
      bus.inst_X     = NOP_INST;
      bus.redirect_X = 1'b0;
      bus.dmem_req_M = 1'b0;
      bus.dmem_ready = 1'b1;
      bus.imem_ready = 1'b1;
   endtask

   task automatic chk_ctrl(input string tag, input logic [4:0] exp);
      #1;
      check({tag, ".pc_en"},   32'(bus.pc_en),   32'(exp[4]));
      check({tag, ".fd_en"},   32'(bus.fd_en),   32'(exp[3]));
      check({tag, ".fd_kill"}, 32'(bus.fd_kill), 32'(exp[2]));
      check({tag, ".x_kill"},  32'(bus.x_kill),  32'(exp[1]));
      check({tag, ".xmw_en"},  32'(bus.xmw_en),  32'(exp[0]));
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [8];
      logic [31:0] w;
      ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111,
              7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111};
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 7)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      idle();
      // Reset values while rst_n is held low.
      chk_ctrl("reset", 5'b00111);
      check("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("reset.flush_cnt", 32'(bus.flush_cnt), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      // Boot: two held cycles, then the PC runs.
      chk_ctrl("boot0", 5'b00111);
      tick(); chk_ctrl("boot1", 5'b00111);
      tick(); chk_ctrl("run0", 5'b11001);
      check("run0.stall_cnt", 32'(bus.stall_cnt), 32'd0);
      // Load-use: one stall cycle, then free flow.
      tick(); bus.inst_X = LW_X5; bus.inst_FD = ADD_X6_X5;
      chk_ctrl("loaduse", 5'b00011);
      tick(); bus.inst_X = ADD_X6_X5; bus.inst_FD = NOP_INST;
      chk_ctrl("after_lu", 5'b11001);
      check("after_lu.stall_cnt", 32'(bus.stall_cnt), 32'd1);
      // Load to x0 is never a hazard.
      tick(); bus.inst_X = LW_X0; bus.inst_FD = ADD_X6_X0;
      chk_ctrl("lw_x0", 5'b11001);
      // Redirect outranks load-use.
      tick(); bus.inst_X = LW_X5; bus.inst_FD = ADD_X6_X5; bus.redirect_X = 1'b1;
      #1;
      check("redir.pc_en",   32'(bus.pc_en),   32'd1);
      check("redir.fd_kill", 32'(bus.fd_kill), 32'd1);
      check("redir.x_kill",  32'(bus.x_kill),  32'd1);
      tick(); idle(); #1;
      check("redir.flush_cnt", 32'(bus.flush_cnt), 32'd1);
      check("redir.stall_cnt", 32'(bus.stall_cnt), 32'd1);
      // Three not-ready cycles with a redirect pending, acted on at release.
      for (int i = 0; i < 3; i++) begin
         tick(); bus.dmem_req_M = 1'b1; bus.dmem_ready = 1'b0; bus.redirect_X = 1'b1;
         chk_ctrl($sformatf("memwait%0d", i), 5'b00000);
      end
      tick(); bus.dmem_ready = 1'b1; #1;
      check("memexit.pc_en",   32'(bus.pc_en),   32'd1);
      check("memexit.fd_kill", 32'(bus.fd_kill), 32'd1);
      check("memexit.x_kill",  32'(bus.x_kill),  32'd1);
      tick(); idle(); #1;
      check("memexit.stall_cnt", 32'(bus.stall_cnt), 32'd4);
      check("memexit.flush_cnt", 32'(bus.flush_cnt), 32'd2);
      // Asynchronous reset in the middle of a memory freeze.
      tick(); bus.dmem_req_M = 1'b1; bus.dmem_ready = 1'b0;
      chk_ctrl("prerst", 5'b00000);
      #1 rst_n = 1'b0;
      chk_ctrl("asyncrst", 5'b00111);
      check("asyncrst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("asyncrst.flush_cnt", 32'(bus.flush_cnt), 32'd0);
      tick(); idle();
      tick(); rst_n = 1'b1;
      chk_ctrl("reboot0", 5'b00111);
      tick(); chk_ctrl("reboot1", 5'b00111);
      tick(); chk_ctrl("rerun", 5'b11001);
      // Stall counter saturates at all-ones.
      tick(); bus.imem_ready = 1'b0;
      chk_ctrl("imem_nr", 5'b00101);
      repeat (40) tick();
      bus.imem_ready = 1'b1; #1;
      check("sat.stall_cnt", 32'(bus.stall_cnt), 32'(MAXC));
      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         bus.inst_FD    = rand_inst();
         bus.inst_X     = rand_inst();
         bus.redirect_X = ($urandom_range(0, 9) < 2);
         bus.dmem_req_M = m_wait ? 1'b1 : ($urandom_range(0, 9) < 3);
         bus.dmem_ready = ($urandom_range(0, 9) < 6);
         bus.imem_ready = ($urandom_range(0, 9) < 8);
      end
      tick(); idle();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
